// File: rtl/eeprom_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | eeprom_arbiter                                                          |
// | Round-robin arbiter/sequencer sharing one serial EEPROM engine between  |
// | two requesters. Optional BUSY timeout: define EEPROM_ARB_TIMEOUT_EN.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module eeprom_arbiter #(
   parameter int TIMEOUT = 50000,
   parameter int TO_W    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_a,
   input  logic        req_b,
   input  logic        rw_a,
   input  logic        rw_b,
   input  logic [10:0] addr_a,
   input  logic [10:0] addr_b,
   input  logic [7:0]  wdata_a,
   input  logic [7:0]  wdata_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        done_a,
   output logic        done_b,
   output logic        err_a,
   output logic        err_b,
   output logic [7:0]  rdata,
   output logic        e_wr,
   output logic        e_rd,
   output logic [10:0] e_addr,
   output logic [7:0]  e_wdata,
   output logic        e_oe,
   input  logic [7:0]  e_rdata,
   input  logic        e_ack
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_BUSY = 3'd2,
      S_DONE = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t state, state_nx;
   logic   owner;     // 0 = A, 1 = B
   logic   last;      // last granted id, same encoding
   logic   rw_q;
   logic   err_q;
   logic   win;
   logic   timeout_hit;

   // A tie goes to whoever was not granted last time.
   always_comb begin
      win = 1'b0;
      if (req_a && req_b)
         win = ~last;
      else if (!req_a)
         win = 1'b1;
   end

`ifdef EEPROM_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (!reset)
         to_cnt <= '0;
      else if (state == S_ARB)
         to_cnt <= '0;
      else if (state == S_BUSY)
         to_cnt <= to_cnt + 1'b1;
   end

   // An ACK on the terminal cycle takes precedence over the abort.
   assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1)) && !e_ack;
`else
   // Untimed build: the timeout parameters have no effect.
   assign timeout_hit = 1'b0 & (TIMEOUT >= (1 << TO_W));
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         owner   <= 1'b0;
         last    <= 1'b1;
         rw_q    <= 1'b0;
         err_q   <= 1'b0;
         e_addr  <= '0;
         e_wdata <= '0;
         rdata   <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && (req_a || req_b)) begin
            owner   <= win;
            last    <= win;
            rw_q    <= win ? rw_b    : rw_a;
            e_addr  <= win ? addr_b  : addr_a;
            e_wdata <= win ? wdata_b : wdata_a;
         end
         if (state == S_BUSY) begin
            err_q <= timeout_hit;
            if (e_ack && rw_q)
               rdata <= e_rdata;
         end
      end
   end

   always_comb begin
      state_nx = state;
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      done_a   = 1'b0;
      done_b   = 1'b0;
      err_a    = 1'b0;
      err_b    = 1'b0;
      e_wr     = 1'b0;
      e_rd     = 1'b0;
      e_oe     = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_a || req_b)
               state_nx = S_ARB;
         end
         S_ARB: begin
            gnt_a    = ~owner;
            gnt_b    = owner;
            state_nx = S_BUSY;
         end
         S_BUSY: begin
            gnt_a = ~owner;
            gnt_b = owner;
            e_wr  = ~rw_q;
            e_rd  = rw_q;
            e_oe  = ~rw_q;
            if (e_ack || timeout_hit)
               state_nx = S_DONE;
         end
         S_DONE: begin
            gnt_a    = ~owner;
            gnt_b    = owner;
            done_a   = ~owner;
            done_b   = owner;
            err_a    = ~owner & err_q;
            err_b    = owner & err_q;
            state_nx = S_GAP;
         end
         S_GAP: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_eeprom_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_eeprom_arbiter                                                       |
// | Randomized self-checking bench for eeprom_arbiter against a             |
// | transaction-level model of the grant/strobe/done schedule.              |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_eeprom_arbiter;

   localparam int TIMEOUT = 16;
   localparam int TO_W    = 16;
   localparam bit A = 1'b0;
   localparam bit B = 1'b1;
   localparam int PH_IDLE = 0, PH_ARB = 1, PH_BUSY = 2, PH_DONE = 3, PH_GAP = 4;
`ifdef EEPROM_ARB_TIMEOUT_EN
   localparam bit TIMED = 1'b1;
`else
   localparam bit TIMED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_a, req_b, rw_a, rw_b;
   logic [10:0] addr_a, addr_b;
   logic [7:0]  wdata_a, wdata_b;
   logic        gnt_a, gnt_b, done_a, done_b, err_a, err_b;
   logic [7:0]  rdata;
   logic        e_wr, e_rd, e_oe;
   logic [10:0] e_addr;
   logic [7:0]  e_wdata;
   logic [7:0]  e_rdata;
   logic        e_ack;

   int vectors     = 0;
   int miscompares = 0;

   // Model: pending request per client, last winner and expected shared regs.
   bit          pend   [2];
   bit          prw    [2];
   logic [10:0] paddr  [2];
   logic [7:0]  pwdata [2];
   bit          last;
   logic [7:0]  exp_rdata;
   logic [10:0] exp_eaddr;
   logic [7:0]  exp_ewdata;

   always #5 clk = ~clk;

   eeprom_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .req_b(req_b), .rw_a(rw_a), .rw_b(rw_b),
      .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
      .err_a(err_a), .err_b(err_b), .rdata(rdata),
      .e_wr(e_wr), .e_rd(e_rd), .e_addr(e_addr), .e_wdata(e_wdata), .e_oe(e_oe),
      .e_rdata(e_rdata), .e_ack(e_ack)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected {gnt_a,gnt_b,done_a,done_b,err_a,err_b,e_wr,e_rd,e_oe} in a phase.
   function automatic logic [8:0] exp_ctl(input int ph, input bit w, input bit rw, input bit err);
      bit own;
      own = (ph == PH_ARB) || (ph == PH_BUSY) || (ph == PH_DONE);
      return {own && w == A, own && w == B,
              ph == PH_DONE && w == A, ph == PH_DONE && w == B,
              ph == PH_DONE && w == A && err, ph == PH_DONE && w == B && err,
              ph == PH_BUSY && !rw, ph == PH_BUSY && rw, ph == PH_BUSY && !rw};
   endfunction

   task automatic check_ctl(input string tag, input int ph, input bit w, input bit rw, input bit err);
      check_val(tag, {23'd0, gnt_a, gnt_b, done_a, done_b, err_a, err_b, e_wr, e_rd, e_oe},
                {23'd0, exp_ctl(ph, w, rw, err)});
   endtask

   task automatic drive_reqs();
      req_a = pend[A]; rw_a = prw[A]; addr_a = paddr[A]; wdata_a = pwdata[A];
      req_b = pend[B]; rw_b = prw[B]; addr_b = paddr[B]; wdata_b = pwdata[B];
   endtask

   task automatic new_req(input bit c, input bit rw, input logic [10:0] ad, input logic [7:0] wd);
      pend[c] = 1'b1; prw[c] = rw; paddr[c] = ad; pwdata[c] = wd;
   endtask

   task automatic clear_model();
      pend[A] = 0; pend[B] = 0; prw[A] = 0; prw[B] = 0;
      paddr[A] = '0; paddr[B] = '0; pwdata[A] = '0; pwdata[B] = '0;
      last = B; exp_rdata = '0; exp_eaddr = '0; exp_ewdata = '0;
   endtask

   // Entered just after an edge with the DUT idle and requests driven.
   // blen > 0: ACK in BUSY cycle blen; blen == 0: never ACK.
   // rst_at > 0: pulse reset low in BUSY cycle rst_at instead of completing.
   task automatic serve(input int blen, input int rst_at, input logic [7:0] rd);
      bit w, rw, err;
      int nb;
      if (pend[A] && pend[B]) w = (last == B) ? A : B;
      else                    w = pend[A] ? A : B;
      last = w;
      rw = prw[w];
      exp_eaddr = paddr[w];
      exp_ewdata = pwdata[w];
      cycle();
      check_ctl("arb_ctl", PH_ARB, w, rw, 0);
      check_val("arb_eaddr", e_addr, exp_eaddr);
      check_val("arb_ewdata", e_wdata, exp_ewdata);
      // The owner's buses are no longer sampled; scramble them.
      if (w == A) begin addr_a = 11'($urandom); wdata_a = 8'($urandom); rw_a = 1'($urandom); end
      else        begin addr_b = 11'($urandom); wdata_b = 8'($urandom); rw_b = 1'($urandom); end
      nb = (blen > 0) ? blen : (TIMED ? TIMEOUT : 1000);
      for (int k = 1; k <= nb; k++) begin
         cycle();
         if (k == rst_at) begin
            reset = 1'b0;
            cycle();
            reset = 1'b1;
            clear_model();
            drive_reqs();
            check_ctl("rst_ctl", PH_IDLE, 0, 0, 0);
            check_val("rst_eaddr", e_addr, 0);
            check_val("rst_ewdata", e_wdata, 0);
            check_val("rst_rdata", rdata, 0);
            return;
         end
         check_ctl("busy_ctl", PH_BUSY, w, rw, 0);
         check_val("busy_eaddr", e_addr, exp_eaddr);
         if (k == blen) begin
            e_ack = 1'b1;
            e_rdata = rd;
            if (rw) exp_rdata = rd;
         end
      end
      err = (blen == 0);
      cycle();
      e_ack = 1'b0;
      e_rdata = 8'($urandom);
      check_ctl("done_ctl", PH_DONE, w, rw, err);
      check_val("done_rdata", rdata, exp_rdata);
      pend[w] = 1'b0;
      drive_reqs();
      cycle();
      check_ctl("gap_ctl", PH_GAP, w, rw, 0);
      check_val("gap_rdata", rdata, exp_rdata);
      e_ack = 1'($urandom);
      cycle();
      e_ack = 1'b0;
      check_ctl("idle_ctl", PH_IDLE, w, rw, 0);
      check_val("idle_rdata", rdata, exp_rdata);
   endtask

   initial begin
      reset = 1'b0; e_ack = 1'b0; e_rdata = '0;
      clear_model();
      drive_reqs();
      cycle();
      cycle();
      check_ctl("reset_ctl", PH_IDLE, 0, 0, 0);
      check_val("reset_rdata", rdata, 0);
      check_val("reset_eaddr", e_addr, 0);
      check_val("reset_ewdata", e_wdata, 0);

      // Contention from reset: A, then B, then A.
      reset = 1'b1;
      new_req(A, 0, 11'h011, 8'h11);
      new_req(B, 1, 11'h022, 8'h22);
      drive_reqs();
      serve(3, 0, 8'h99);
      new_req(A, 1, 11'h033, 8'h33); drive_reqs();
      serve(1, 0, 8'h3C);
      new_req(B, 0, 11'h044, 8'h44); drive_reqs();
      serve(2, 0, 8'h77);
      pend[B] = 0; drive_reqs();
      cycle();

      // Single write and single read.
      new_req(A, 0, 11'h123, 8'h5A); drive_reqs();
      serve(20, 0, 8'hEE);
      new_req(B, 1, 11'h7FF, 8'h00); drive_reqs();
      serve(1, 0, 8'hC3);
      cycle();
      check_val("rdata_held", rdata, 8'hC3);

      // Reset mid-BUSY, then the tie must go to A again.
      new_req(B, 0, 11'h2AA, 8'h55); drive_reqs();
      serve(2, 0, 8'h01);
      new_req(A, 1, 11'h100, 8'h01);
      new_req(B, 1, 11'h200, 8'h02); drive_reqs();
      serve(10, 3, 8'h00);
      new_req(A, 0, 11'h155, 8'hA5);
      new_req(B, 0, 11'h2AA, 8'h5A); drive_reqs();
      serve(2, 0, 8'h00);
      serve(1, 0, 8'h00);

      // No ACK: timed build aborts with ERR, untimed build waits until reset.
      new_req(A, 1, 11'h0F0, 8'h00); drive_reqs();
      if (TIMED) begin
         serve(0, 0, 8'h00);
         new_req(A, 1, 11'h0F1, 8'h00); drive_reqs();
         serve(TIMEOUT, 0, 8'h6D);
      end else begin
         serve(0, 1000, 8'h00);
      end

      for (int it = 0; it < 200; it++) begin
         for (int c = 0; c < 2; c++)
            if (!pend[c] && $urandom_range(0, 1) == 1)
               new_req(1'(c), 1'($urandom), 11'($urandom), 8'($urandom));
         drive_reqs();
         if (!pend[A] && !pend[B]) begin
            e_ack = 1'($urandom);
            cycle();
            e_ack = 1'b0;
            check_ctl("idle_stray", PH_IDLE, 0, 0, 0);
            check_val("idle_stray_rdata", rdata, exp_rdata);
         end else begin
            serve(int'($urandom_range(1, 6)), 0, 8'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Round-robin arbiter and sequencer that shares one serial EEPROM read/write engine between two requesters (A, B). It latches a winning request, drives the engine's WR/RD strobes, address and write data, waits for the engine's per-transfer ACK, captures read data, and returns a completion pulse to the owner. It sits between system-side clients (e.g. config loader, host port) and the EEPROM engine's parallel interface.

## Interface
- TIMEOUT, 50000: BUSY cycles without E_ACK before abort (used only with EEPROM_ARB_TIMEOUT_EN)
- TO_W, 16: timeout counter width; must satisfy 2^TO_W > TIMEOUT
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- REQ_A / REQ_B  in  1  request, held high until DONE_x
- RW_A / RW_B  in  1  1 = read, 0 = write
- ADDR_A / ADDR_B  in  11  EEPROM byte address
- WDATA_A / WDATA_B  in  8  write byte
- GNT_A / GNT_B  out  1  high from ARB through DONE while owner
- DONE_A / DONE_B  out  1  one-cycle completion pulse
- ERR_A / ERR_B  out  1  one-cycle timeout pulse, coincident with DONE_x
- RDATA  out  8  last read byte, shared
- E_WR / E_RD  out  1  engine write/read strobe (level)
- E_ADDR  out  11  engine address
- E_WDATA  out  8  engine write byte
- E_OE  out  1  enable for external tristate onto engine DATA bus
- E_RDATA  in  8  engine read byte
- E_ACK  in  1  engine transfer-complete pulse

## Operation
- States: IDLE, ARB, BUSY, DONE, GAP (one-hot or binary, implementer's choice).
- IDLE: if REQ_A|REQ_B -> ARB; latch winner id, RW, ADDR, WDATA into internal regs.
- Winner: single requester wins; both high -> the one not in LAST (last-granted id). LAST updates on entering ARB.
- ARB: GNT_winner=1; E_ADDR/E_WDATA driven from latched regs -> BUSY.
- BUSY: E_WR=~rw or E_RD=rw held high; E_OE=~rw. On E_ACK=1 -> DONE; if read, RDATA<=E_RDATA on the same edge.
- DONE: DONE_winner=1 for one cycle, strobes low -> GAP.
- GAP: all strobes and GNT low for one cycle (engine returns to idle) -> IDLE.
- REQ and request buses ignored outside IDLE; changing them after ARB has no effect.
- REQ dropped before sampled in IDLE: never granted.
- E_ACK outside BUSY: ignored.
- RDATA unchanged by writes and by aborted reads.

## Timing
- Reset values: GNT_x, DONE_x, ERR_x, E_WR, E_RD, E_OE = 0; RDATA, E_ADDR, E_WDATA = 0; LAST = B (A wins first tie); state IDLE; timeout counter 0.
- REQ high at edge n -> ARB/GNT at n+1 -> BUSY strobe at n+2.
- E_ACK sampled at edge m in BUSY -> DONE at m+1 (RDATA valid) -> GAP m+2 -> IDLE m+3.
- Minimum REQ-to-DONE: 3 cycles; back-to-back service period: BUSY length + 4 cycles.
- E_ACK in the first BUSY cycle is honoured.
- RESET low mid-transfer: next edge forces all reset values; no DONE issued; pending requesters must re-request. The engine shares RESET.

## Configuration
- EEPROM_ARB_TIMEOUT_EN defined: counter clears on entering BUSY, increments each BUSY cycle; reaching TIMEOUT-1 without E_ACK -> DONE with ERR_winner=1 and DONE_winner=1, RDATA unchanged. E_ACK on the terminal cycle wins (no ERR).
- Undefined: no counter; BUSY waits indefinitely; ERR_A/ERR_B tied 0.

## Test plan
- Single write: REQ_A, RW_A=0, ADDR_A=11'h123, WDATA_A=8'h5A, E_ACK after 20 BUSY cycles -> E_WR high 20 cycles, E_ADDR=123h, E_WDATA=5Ah, E_OE=1, DONE_A pulse at ack+1, ERR_A=0.
- Single read: REQ_B, RW_B=1, ADDR_B=11'h7FF, E_RDATA=8'hC3 with E_ACK -> E_RD high, E_OE=0, RDATA=C3h in DONE_B cycle and held after.
- Contention: REQ_A and REQ_B both high from reset, held -> A served first, then B, then A again; GAP of one cycle between each DONE and next ARB.
- Reset mid-BUSY: drop RESET for one cycle during BUSY -> E_RD/E_WR, GNT_x 0 next edge, no DONE, LAST back to B.
- Timeout (macro on, TIMEOUT=16): no E_ACK -> DONE_A and ERR_A together 16 cycles after BUSY entry, RDATA unchanged; macro off -> BUSY persists 1000 cycles, ERR_A stays 0.
- Stray ACK: E_ACK pulse in IDLE and in GAP -> no state change, no DONE.
